// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents:
//   WORD_W            datapath / address width
//   PC_INC            byte stride between consecutive instruction words
//   RESET_PC_DEFAULT  default fetch PC after reset
//   fetch_entry_t     one buffered instruction: word, its PC and PC+4
//   align_word()      clears the byte-offset bits of an address
package mips_fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc4;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO holding fetched instruction entries.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, push_data   write one entry (ignored when full unless popping too)
//   pop               remove the head entry (ignored when empty)
//   flush             empty the FIFO next cycle; overrides push and pop
//   head              current head entry (register read, stable until popped)
//   count             number of entries held
//   full, empty       occupancy flags
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & !empty & !flush;
  assign do_push = push & !flush & (!full | do_pop);

  assign head = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to
// instruction memory and buffers returned words (with PC and PC+4) for the core.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   imem_req, imem_addr           read request and its word address
//   imem_gnt                      memory accepts the request this cycle
//   imem_rvalid, imem_rdata       in-order read responses
//   redirect_valid, redirect_pc   core redirect (branch / jump / jr)
//   inst_valid, inst_ready        head handshake towards the core
//   inst_word, inst_pc, inst_pc4  head entry contents (zero when not valid)
//   misalign_err                  one-cycle pulse after a misaligned redirect
module instr_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_word,
  output logic [WORD_W-1:0] inst_pc,
  output logic [WORD_W-1:0] inst_pc4,
  output logic              misalign_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [WORD_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic [WORD_W-1:0] pc_tag;
  logic              accept;
  logic              push_en;
  logic              pop_en;

  // Credit rule: buffered plus in-flight words never exceed the queue depth,
  // so every response always has a slot waiting for it.
  assign imem_req = !rst && !redirect_valid && !fifo_full
                    && (outstanding < CNT_W'(MAX_OUTST))
                    && (({1'b0, fifo_count} + {1'b0, outstanding}) < SUM_W'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_gnt;

  // Responses arrive in request order, so the returning word belongs to the
  // oldest in-flight request. Only used when no dropped responses remain, in
  // which case every in-flight request was issued from the current fetch_pc run.
  assign pc_tag = fetch_pc - WORD_W'({outstanding, 2'b00});

  assign push_entry.word = imem_rdata;
  assign push_entry.pc   = pc_tag;
  assign push_entry.pc4  = pc_tag + PC_INC;

  assign push_en = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign pop_en  = inst_valid && inst_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop_en),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst_word  = inst_valid ? fifo_head.word : '0;
  assign inst_pc    = inst_valid ? fifo_head.pc   : '0;
  assign inst_pc4   = inst_valid ? fifo_head.pc4  : '0;

  // Fetch PC, in-flight accounting and redirect handling. A redirect turns
  // every request still in flight into one that must be discarded on return.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      misalign_err <= 1'b0;
    end else begin
      outstanding  <= outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        fetch_pc <= align_word(redirect_pc);
        drop_cnt <= outstanding - CNT_W'(imem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_INC;
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a directed vector table, hand
// sequences for redirect / wrap / reset corners, then randomized traffic
// checked against a stream-level model of the expected instruction order.
module tb_instr_fetch_queue;
  import mips_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        misalign_err;

  instr_fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  mem_req_t    pending[$];
  vec_t        vecs[$];
  int          checks;
  int          failures;
  int          cycle;
  int          pop_count;
  int          lat_min;
  int          lat_max;
  logic        gnt_random;
  logic [31:0] exp_pc;
  logic [31:0] exp_req_addr;
  logic        mis_exp;
  logic [31:0] last_pop_pc;
  logic [31:0] last_pop_pc4;
  logic        smp_valid;
  logic [31:0] smp_pc;
  logic        smp_req;
  logic [31:0] smp_addr;

  // Content of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void addVec(input logic rdy, input logic ev, input logic [31:0] epc,
                                 input logic erq, input logic [31:0] ead);
    vec_t v;
    v.ready = rdy; v.exp_valid = ev; v.exp_pc = epc; v.exp_req = erq; v.exp_addr = ead;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive core and memory inputs, check what the DUT shows
  // in this cycle against the model, then advance the model past the edge.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic     accepted;
    logic     popped;
    mem_req_t r;
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_gnt       = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && pending.size() > 0 && pending[0].due <= cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pending[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    smp_valid = inst_valid;
    smp_pc    = inst_pc;
    smp_req   = imem_req;
    smp_addr  = imem_addr;
    accepted  = imem_req & imem_gnt;
    popped    = !rst & inst_valid & rdy & !rv;
    if (!rst) begin
      checkOutput("misalign_err", 32'(misalign_err), 32'(mis_exp));
      if (rv) checkOutput("req_during_redirect", 32'(imem_req), 32'd0);
    end
    if (accepted) begin
      checkOutput("req_addr", imem_addr, exp_req_addr);
      checkOutput("outstanding_limit", 32'(pending.size() < MAX_OUTST), 32'd1);
    end
    if (popped) begin
      checkOutput("pop_pc", inst_pc, exp_pc);
      checkOutput("pop_word", inst_word, memWord(exp_pc));
      checkOutput("pop_pc4", inst_pc4, exp_pc + 32'd4);
      last_pop_pc  = inst_pc;
      last_pop_pc4 = inst_pc4;
      pop_count++;
    end
    @(posedge clk);
    if (rst) begin
      pending.delete();
      exp_pc       = RESET_PC;
      exp_req_addr = RESET_PC;
      mis_exp      = 1'b0;
    end else begin
      if (imem_rvalid) void'(pending.pop_front());
      if (accepted) begin
        r.addr = smp_addr;
        r.due  = cycle + int'($urandom_range(lat_min, lat_max));
        pending.push_back(r);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (popped) exp_pc = exp_pc + 32'd4;
      if (rv) begin
        exp_pc       = {rpc[31:2], 2'b00};
        exp_req_addr = {rpc[31:2], 2'b00};
        mis_exp      = (rpc[1:0] != 2'b00);
      end else begin
        mis_exp = 1'b0;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic runUntilPop(input int bound, input string name);
    int start;
    start = pop_count;
    for (int i = 0; i < bound && pop_count == start; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    if (pop_count == start) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic        found;
    logic        rv;
    logic [31:0] rpc;
    checks = 0; failures = 0; cycle = 0; pop_count = 0;
    lat_min = 1; lat_max = 1; gnt_random = 1'b0;
    exp_pc = RESET_PC; exp_req_addr = RESET_PC; mis_exp = 1'b0;
    last_pop_pc = '0; last_pop_pc4 = '0;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Fill, steady stream, 10-cycle stall with a full queue, then drain.
    addVec(1, 0, 32'h00, 1, 32'h00);
    addVec(1, 0, 32'h00, 1, 32'h04);
    addVec(1, 1, 32'h00, 1, 32'h08);
    addVec(1, 1, 32'h04, 1, 32'h0C);
    addVec(1, 1, 32'h08, 1, 32'h10);
    addVec(1, 1, 32'h0C, 1, 32'h14);
    addVec(0, 1, 32'h10, 1, 32'h18);
    addVec(0, 1, 32'h10, 1, 32'h1C);
    for (int i = 0; i < 8; i++) addVec(0, 1, 32'h10, 0, 32'h00);
    addVec(1, 1, 32'h10, 0, 32'h00);
    addVec(1, 1, 32'h14, 1, 32'h20);
    addVec(1, 1, 32'h18, 1, 32'h24);
    addVec(1, 1, 32'h1C, 1, 32'h28);
    addVec(1, 1, 32'h20, 1, 32'h2C);
    addVec(1, 1, 32'h24, 1, 32'h30);

    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("reset_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset_req", 32'(imem_req), 32'd0);
    checkOutput("reset_misalign", 32'(misalign_err), 32'd0);
    checkOutput("reset_word", inst_word, 32'd0);
    checkOutput("reset_pc", inst_pc, 32'd0);
    checkOutput("reset_addr", imem_addr, RESET_PC);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ready, 1'b0, 32'h0);
      checkOutput($sformatf("tbl_valid[%0d]", i), 32'(smp_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) checkOutput($sformatf("tbl_pc[%0d]", i), smp_pc, vecs[i].exp_pc);
      checkOutput($sformatf("tbl_req[%0d]", i), 32'(smp_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) checkOutput($sformatf("tbl_addr[%0d]", i), smp_addr, vecs[i].exp_addr);
    end

    // Redirect with two requests in flight: both responses must be discarded.
    doReset();
    lat_min = 3; lat_max = 3;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("inflight_count", 32'(pending.size()), 32'd2);
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("redir_flush_valid", 32'(inst_valid), 32'd0);
    checkOutput("redir_no_misalign", 32'(misalign_err), 32'd0);
    runUntilPop(40, "redir_pop");
    checkOutput("redir_first_pc", last_pop_pc, 32'h100);

    // Redirect coinciding with a response and a pop, one more request in flight.
    doReset();
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pending.size() == 2 && pending[0].due <= cycle && inst_valid) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput("coincident_setup", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h200);
    checkOutput("coincident_flush", 32'(inst_valid), 32'd0);
    runUntilPop(40, "coincident_pop");
    checkOutput("coincident_first_pc", last_pop_pc, 32'h200);

    // Misaligned redirect target.
    lat_min = 1; lat_max = 1;
    applyStimulus(1'b1, 1'b1, 32'h102);
    checkOutput("misalign_pulse", 32'(misalign_err), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("misalign_clear", 32'(misalign_err), 32'd0);
    runUntilPop(40, "misalign_pop");
    checkOutput("misalign_first_pc", last_pop_pc, 32'h100);

    // Fetch PC wrap at the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    runUntilPop(40, "wrap_pop1");
    checkOutput("wrap_pc_top", last_pop_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4_top", last_pop_pc4, 32'h0000_0000);
    runUntilPop(40, "wrap_pop2");
    checkOutput("wrap_pc_zero", last_pop_pc, 32'h0000_0000);

    // Reset in the middle of a stream.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
    checkOutput("midrst_addr", imem_addr, RESET_PC);
    runUntilPop(40, "midrst_pop");
    checkOutput("midrst_first_pc", last_pop_pc, RESET_PC);

    // Randomized traffic: random grant, latency, ready, redirects and resets.
    gnt_random = 1'b1;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 39) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus(($urandom_range(0, 9) < 7), rv, rpc);
    end
    rst = 1'b0;
    gnt_random = 1'b0;
    runUntilPop(60, "drain_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
